// File: rtl/cmos_pkg.sv
// Shared state encoding, colour-bar table and pixel conversion for the camera frame writer.
// The colour-bar table is only consumed when CMOS_TEST_PATTERN_EN is defined.
package cmos_pkg;

  localparam int FRAME_PIXELS_DEF = 786432;
  localparam int H_PIXELS_DEF     = 1024;

  typedef enum logic [1:0] {
    S_SKIP    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_REQ     = 2'd2,
    S_WRITE   = 2'd3
  } state_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][15:0] BAR_RGB565 = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  // Widen each channel by replicating its top bits into the new LSBs.
  function automatic logic [31:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2], 8'h00};
  endfunction

endpackage

// File: rtl/cmos_frame_writer_rgb565_to_rgb888.sv
// Registered RGB565 -> {R8,G8,B8,8'h00} converter; provides the fixed one-cycle write latency.
module rgb565_to_rgb888
  import cmos_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic        valid_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) data_q <= rgb565_to_888(in_data);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cmos_frame_writer.sv
// Camera-side frame writer: settles for SKIP_FRAMES, requests a burst, streams one frame of RGB888.
// Define CMOS_TEST_PATTERN_EN to replace camera pixels with 8 vertical colour bars.
module cmos_frame_writer
  import cmos_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int SKIP_FRAMES  = 2,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  output logic        write_req,
  input  logic        write_req_ack,
  output logic        write_en,
  output logic [31:0] write_data,
  output logic        frame_done,
  output logic        short_frame,
  output logic        long_frame
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] SKIP_CNT  = CNT_W'(SKIP_FRAMES);

  state_e           state_q, state_d;
  logic             vs_q, vs_d1_q;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             seen_start_q, seen_start_d;
  logic             write_req_q, write_req_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             frame_start, frame_end, accept;
  logic [15:0]      pix_src;

  assign frame_start = vs_d1_q & ~vs_q;
  assign frame_end   = ~vs_d1_q & vs_q;

  // A frame end only counts towards settling if its start was seen after reset,
  // so the partial frame around a reset release is never counted.
  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    seen_start_d = seen_start_q;
    write_req_d  = write_req_q;
    done_d       = 1'b0;
    short_d      = short_q;
    long_d       = long_q;
    accept       = 1'b0;
    case (state_q)
      S_SKIP: begin
        if (frame_start) seen_start_d = 1'b1;
        if (skip_cnt_q == SKIP_CNT) begin
          state_d = S_WAIT_VS;
        end else if (frame_end && seen_start_q) begin
          skip_cnt_d   = skip_cnt_q + CNT_W'(1);
          seen_start_d = 1'b0;
        end
      end
      S_WAIT_VS: begin
        if (frame_start) begin
          write_req_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (frame_end) begin
          write_req_d = 1'b0;
          state_d     = S_WAIT_VS;
        end else if (write_req_ack) begin
          write_req_d = 1'b0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (frame_valid) begin
          if (pix_cnt_q < FRAME_CNT) begin
            accept    = 1'b1;
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end else begin
            long_d = 1'b1;
          end
        end
        if (frame_end) begin
          done_d    = 1'b1;
          pix_cnt_d = '0;
          state_d   = S_WAIT_VS;
          if (pix_cnt_q < FRAME_CNT) short_d = 1'b1;
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      vs_d1_q      <= 1'b0;
      state_q      <= S_SKIP;
      skip_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      seen_start_q <= 1'b0;
      write_req_q  <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      vs_q         <= frame_vsync;
      vs_d1_q      <= vs_q;
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      seen_start_q <= seen_start_d;
      write_req_q  <= write_req_d;
      done_q       <= done_d;
      short_q      <= short_d;
      long_q       <= long_d;
    end
  end

`ifdef CMOS_TEST_PATTERN_EN
  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int BAR_W = (H_PIXELS >= 8) ? H_PIXELS / 8 : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       bar_idx;

  always_comb begin
    col_d = col_q;
    if (frame_start) col_d = '0;
    else if (frame_valid) col_d = (col_q == COL_W'(H_PIXELS - 1)) ? '0 : col_q + COL_W'(1);
    bar_idx = 3'(col_q / COL_W'(BAR_W));
    pix_src = BAR_RGB565[bar_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= '0;
    else        col_q <= col_d;
  end
`else
  assign pix_src = frame_data;
`endif

  rgb565_to_rgb888 u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_data  (pix_src),
    .out_valid(write_en),
    .out_data (write_data)
  );

  assign write_req   = write_req_q;
  assign frame_done  = done_q;
  assign short_frame = short_q;
  assign long_frame  = long_q;

endmodule
